// File: rtl/fetch_pkg.sv
// Shared constants, FSM state type and helpers for the fetch controller.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR   = 32'h3000_0000;
  localparam logic [3:0]  HALT_OPCODE = 4'b1111;

  typedef enum logic [1:0] {
    StFetch,
    StDrain,
    StHalt,
    StDone
  } fetch_state_e;

  function automatic logic is_halt(input logic [31:0] instr);
    return instr[31:28] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer holding {pc, instr} pairs; flush takes priority over push and pop.
module fetch_fifo #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [63:0]                   push_data,
  input  logic                          pop,
  input  logic                          flush,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          empty,
  output logic [63:0]                   head
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [63:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign do_pop  = pop && !flush && !empty;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the head is only observed when count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data;
  end

  assign head  = mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: sequences memory requests, buffers words, handles redirect/stall/halt.
// Optional perf counters (fetch_cnt_o, bubble_cnt_o) are built when FETCH_PERF_EN is defined.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] PC_RESET   = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_valid_o,
  output logic        halted_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_q;
  logic          req_q, halted_q;
  logic [31:0]   pc_q, redir_pc_q;

  logic [CW-1:0] count, count_next;
  logic          empty, fifo_room;
  logic [63:0]   head;
  logic          ack, push, pop, flush, halt_push, halt_pop;

  fetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({pc_q, mem_data_i}),
    .pop       (pop),
    .flush     (flush),
    .count     (count),
    .empty     (empty),
    .head      (head)
  );

  assign ack           = req_q && mem_ack_i;
  assign instr_valid_o = !empty && (state_q != StDone);
  assign pop           = instr_valid_o && !stall_i;

  always_comb begin
    push  = 1'b0;
    flush = 1'b0;
    unique case (state_q)
      StFetch: begin
        flush = redirect_i;
        push  = ack && !redirect_i;
      end
      StDrain, StHalt: flush = redirect_i;
      StDone: begin
      end
    endcase
  end

  // Occupancy after this cycle's push/pop decides whether the next request fits.
  assign count_next = count + CW'(push) - CW'(pop);
  assign fifo_room  = count_next < CW'(FIFO_DEPTH);
  assign halt_push  = push && is_halt(mem_data_i);
  assign halt_pop   = pop && is_halt(head[31:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      req_q      <= 1'b0;
      pc_q       <= PC_RESET;
      redir_pc_q <= PC_RESET;
      halted_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (redirect_i) begin
            if (!req_q || mem_ack_i) begin
              pc_q  <= redirect_pc_i;
              req_q <= 1'b1;
            end else begin
              // An issued request cannot be withdrawn; wait out its ack.
              redir_pc_q <= redirect_pc_i;
              state_q    <= StDrain;
            end
          end else if (halt_push) begin
            pc_q    <= pc_q + 32'd1;
            req_q   <= 1'b0;
            state_q <= StHalt;
          end else if (ack) begin
            pc_q  <= pc_q + 32'd1;
            req_q <= fifo_room;
          end else if (!req_q) begin
            req_q <= fifo_room;
          end
        end
        StDrain: begin
          if (redirect_i) redir_pc_q <= redirect_pc_i;
          if (mem_ack_i) begin
            pc_q    <= redirect_i ? redirect_pc_i : redir_pc_q;
            state_q <= StFetch;
          end
        end
        StHalt: begin
          if (redirect_i) begin
            pc_q    <= redirect_pc_i;
            req_q   <= 1'b1;
            state_q <= StFetch;
          end else if (halt_pop) begin
            halted_q <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
        end
      endcase
    end
  end

  assign mem_req_o  = req_q;
  assign mem_addr_o = pc_q;
  assign halted_o   = halted_q;
  assign instr_o    = instr_valid_o ? head[31:0] : NOP_INSTR;
  assign instr_pc_o = instr_valid_o ? head[63:32] : 32'h0;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_o  <= 32'h0;
      bubble_cnt_o <= 32'h0;
    end else begin
      if (ack) fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (!instr_valid_o && state_q != StDone) bubble_cnt_o <= bubble_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch controller sitting between the PC/branch logic and the instruction memory. It sequences word-addressed fetch requests over a req/ack handshake and buffers returned instructions in a small FIFO. It feeds decode with either a valid instruction or the standard bubble, and handles redirects (flush), decode stall and the halt opcode.

## Interface

- `FIFO_DEPTH`, 4 — instruction buffer entries; power of two, ≥2.
- `PC_RESET`, 32'h0 — first fetch address after reset.
- `clk` input 1 — single clock, rising edge.
- `rst_n` input 1 — reset; asynchronous assert, active-low.
- `mem_req_o` output 1 — fetch request to instruction memory.
- `mem_addr_o` output 32 — word address; stable while `mem_req_o` high.
- `mem_ack_i` input 1 — memory accepts request and returns data in same cycle.
- `mem_data_i` input 32 — instruction word, valid when `mem_ack_i`.
- `redirect_i` input 1 — branch/jump taken; flush and refetch.
- `redirect_pc_i` input 32 — new fetch address.
- `stall_i` input 1 — decode cannot accept this cycle.
- `instr_o` output 32 — FIFO head, or NOP 32'h3000_0000 when empty.
- `instr_pc_o` output 32 — address of `instr_o`; 0 when empty.
- `instr_valid_o` output 1 — `instr_o` is a real instruction.
- `halted_o` output 1 — halt instruction delivered; sticky until reset.

## Operation

- FSM states: FETCH, DRAIN, HALT, DONE.
- FETCH: `mem_req_o` high whenever post-update occupancy (count + push − pop) < FIFO_DEPTH. Once raised, req and addr are held until `mem_ack_i`. On ack: push {addr, data}; fetch_pc += 1 (wraps at 2^32).
- Pop when `instr_valid_o && !stall_i`. Simultaneous push/pop is legal; count is unchanged.
- Redirect with no request pending, or with ack in the same cycle: flush FIFO, discard the acked data, fetch_pc = `redirect_pc_i`, stay in FETCH.
- Redirect while req is high and unacked: req cannot be withdrawn. Flush FIFO, latch `redirect_pc_i`, go to DRAIN.
- DRAIN: hold req until ack, discard data, then go to FETCH with the latched PC. A further redirect in DRAIN overwrites the latched PC.
- Halt detection: a pushed word with [31:28] = 4'b1111 stops further requests and moves the FSM to HALT. The FIFO keeps draining.
- HALT to DONE: when the halt word is popped, `halted_o` goes to 1 and `instr_valid_o` is forced to 0 thereafter.
- Redirect in HALT (older branch): flush, cancel halt, return to FETCH.
- DONE ignores redirects; only reset leaves it.
- `stall_i` never blocks fetching, only popping.

## Timing

- Reset values:
  - `mem_req_o` = 0, `mem_addr_o` = PC_RESET
  - `instr_valid_o` = 0, `instr_o` = 32'h3000_0000, `instr_pc_o` = 0
  - `halted_o` = 0, FIFO empty, state FETCH
- First `mem_req_o` is asserted the first cycle after `rst_n` deasserts.
- `mem_req_o` and `mem_addr_o` are registered. Ack at cycle t gives the next request at t+1, so a zero-wait memory sustains 1 fetch/cycle.
- Pushed data appears on `instr_o` at t+1. `instr_o`/`instr_valid_o` come combinationally from registered FIFO storage.
- Redirect at t: outputs show NOP/invalid at t+1. With no pending request, the redirect-target req is issued at t+1.
- Reset asserted mid-transaction: all state clears immediately. The memory must tolerate the dropped req.

## Configuration

- `FETCH_PERF_EN` defined: adds outputs `fetch_cnt_o` [31:0] (acks accepted, including discarded ones) and `bubble_cnt_o` [31:0] (cycles with `instr_valid_o` = 0 before DONE). Both reset to 0, wrap, and are not cleared by redirect.
- Undefined: these ports and counters are absent; the rest of the behaviour is identical.

## Structure

- Shared `fetch_pkg`:
  - `NOP_INSTR` = 32'h3000_0000
  - `HALT_OPCODE` = 4'b1111
  - FSM state enum
- Sub-module `fetch_fifo`: parameterised by FIFO_DEPTH, 64-bit entries {pc, instr}, with push/pop/flush, count, and head outputs.

## Test plan

- Reset, zero-wait memory returning mem[a] = a, `stall_i` = 0: `mem_addr_o` runs 0,1,2,…; `instr_o` = 0,1,2 from cycle 2 onward, valid every cycle.
- `stall_i` held 10 cycles, FIFO_DEPTH = 4: exactly 4 acks, then `mem_req_o` = 0 and `instr_o` stable on PC 0. On release, draining and refetch resume with no gap.
- Memory with 3-cycle ack latency, redirect to 0x100 on the second wait cycle: the returning word is discarded (never valid), next `mem_addr_o` = 0x100, and `instr_pc_o` = 0x100 is the first valid output.
- Redirect to 0x40 in the same cycle as an ack for addr 5: word 5 is not delivered; the req at the next cycle has addr 0x40.
- mem[3] = 32'hF000_0000: no request issued above address 3, words 0–2 delivered. `halted_o` rises in the cycle after word 3 pops; later redirects are ignored.
- Halt word buffered, then redirect to 0x20 before it pops: halt cancelled, fetch resumes at 0x20, `halted_o` stays 0.
